// File: rtl/arc4_pkg.sv
// Shared types and constants for the parametrised ARC4 decrypt engine.
package arc4_pkg;

   localparam int         SBOX_SIZE = 256;
   localparam logic [7:0] PRINT_LO  = 8'h20;
   localparam logic [7:0] PRINT_HI  = 8'h7E;

   // IDLE -> INIT -> KSA -> LEN -> PRGA -> IDLE; KSA and PRGA are split into
   // sub-steps because the S-box has a single read and a single write port.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_KSA_RI,
      ST_KSA_RJ,
      ST_KSA_WI,
      ST_LEN,
      ST_PRGA_NXT,
      ST_PRGA_RI,
      ST_PRGA_RJ,
      ST_PRGA_WI,
      ST_PRGA_PAD
   } arc4_state_t;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= PRINT_LO) && (b <= PRINT_HI);
   endfunction

endpackage

// File: rtl/arc4_sbox.sv
// 256x8 S-box storage: combinational read port, synchronous write port.
module arc4_sbox
   import arc4_pkg::*;
(
   input  logic       clk,
   input  logic [7:0] raddr,
   output logic [7:0] rdata,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata
);

   logic [7:0] mem_q [SBOX_SIZE];

   // Contents need no reset; INIT rebuilds them before every run.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/arc4_core_param.sv
// ARC4 decrypt engine: reads a length-prefixed ciphertext, writes the
// length-prefixed plaintext, optionally aborting on a non-printable byte.
module arc4_core_param
   import arc4_pkg::*;
#(
   parameter int KEY_BYTES  = 3,
   parameter int CHECK_MODE = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid,
   output logic                   ready,
   input  logic [8*KEY_BYTES-1:0] key,
   output logic [7:0]             em_addr,
   input  logic [7:0]             em_rddata,
   output logic [7:0]             dm_addr,
   output logic [7:0]             dm_wrdata,
   output logic                   dm_wren,
   output logic                   result_ok
);

   localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   arc4_state_t            state_q, state_d;
   logic [8*KEY_BYTES-1:0] key_q, key_d;
   logic [7:0]             i_q, i_d, j_q, j_d;
   logic [7:0]             si_q, si_d, sj_q, sj_d;
   logic [7:0]             len_q, len_d;
   logic [8:0]             k_q, k_d;
   logic [KW-1:0]          kidx_q, kidx_d;
   logic [7:0]             em_addr_q, em_addr_d;
   logic [7:0]             dm_addr_q, dm_addr_d;
   logic [7:0]             dm_wrdata_q, dm_wrdata_d;
   logic                   dm_wren_q, dm_wren_d;
   logic                   result_ok_q, result_ok_d;

   logic [7:0] s_raddr, s_rdata, s_waddr, s_wdata;
   logic       s_we;
   logic [7:0] key_byte, pt, pad_idx;
   logic [8:0] k_inc;
   logic [7:0] key_bytes [KEY_BYTES];

   // Key byte 0 is the most significant byte of the key bus.
   for (genvar g = 0; g < KEY_BYTES; g++) begin : g_kb
      assign key_bytes[g] = key_q[8*KEY_BYTES-1-8*g -: 8];
   end

   assign key_byte = key_bytes[kidx_q];
   assign pad_idx  = si_q + sj_q;
   assign pt       = em_rddata ^ s_rdata;
   assign k_inc    = k_q + 9'd1;

   arc4_sbox u_sbox (
      .clk   (clk),
      .raddr (s_raddr),
      .rdata (s_rdata),
      .we    (s_we),
      .waddr (s_waddr),
      .wdata (s_wdata)
   );

   // Next-state, datapath and S-box port control.
   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      i_d         = i_q;
      j_d         = j_q;
      si_d        = si_q;
      sj_d        = sj_q;
      len_d       = len_q;
      k_d         = k_q;
      kidx_d      = kidx_q;
      em_addr_d   = em_addr_q;
      dm_addr_d   = dm_addr_q;
      dm_wrdata_d = dm_wrdata_q;
      dm_wren_d   = 1'b0;
      result_ok_d = result_ok_q;
      s_raddr     = i_q;
      s_we        = 1'b0;
      s_waddr     = i_q;
      s_wdata     = i_q;
      case (state_q)
         ST_IDLE: begin
            if (valid) begin
               key_d       = key;
               result_ok_d = 1'b0;
               i_d         = 8'd0;
               em_addr_d   = 8'd0;
               state_d     = ST_INIT;
            end
         end
         ST_INIT: begin
            s_we = 1'b1;
            i_d  = i_q + 8'd1;
            if (i_q == 8'hFF) begin
               j_d     = 8'd0;
               kidx_d  = '0;
               state_d = ST_KSA_RI;
            end
         end
         ST_KSA_RI: begin
            si_d    = s_rdata;
            j_d     = j_q + s_rdata + key_byte;
            state_d = ST_KSA_RJ;
         end
         ST_KSA_RJ, ST_PRGA_RJ: begin
            // Read S[j] before it is overwritten with the old S[i].
            s_raddr = j_q;
            sj_d    = s_rdata;
            s_we    = 1'b1;
            s_waddr = j_q;
            s_wdata = si_q;
            state_d = (state_q == ST_KSA_RJ) ? ST_KSA_WI : ST_PRGA_WI;
         end
         ST_KSA_WI: begin
            s_we    = 1'b1;
            s_wdata = sj_q;
            i_d     = i_q + 8'd1;
            kidx_d  = (kidx_q == KW'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
            state_d = (i_q == 8'hFF) ? ST_LEN : ST_KSA_RI;
         end
         ST_LEN: begin
            // em_addr has sat at 0 since acceptance, so the header is valid.
            len_d       = em_rddata;
            dm_addr_d   = 8'd0;
            dm_wrdata_d = em_rddata;
            dm_wren_d   = 1'b1;
            em_addr_d   = 8'd1;
            k_d         = 9'd1;
            i_d         = 8'd0;
            j_d         = 8'd0;
            state_d     = ST_PRGA_NXT;
         end
         ST_PRGA_NXT: begin
            if (k_q > {1'b0, len_q}) begin
               result_ok_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               i_d     = i_q + 8'd1;
               state_d = ST_PRGA_RI;
            end
         end
         ST_PRGA_RI: begin
            si_d    = s_rdata;
            j_d     = j_q + s_rdata;
            state_d = ST_PRGA_RJ;
         end
         ST_PRGA_WI: begin
            s_we    = 1'b1;
            s_wdata = sj_q;
            state_d = ST_PRGA_PAD;
         end
         ST_PRGA_PAD: begin
            s_raddr = pad_idx;
            if ((CHECK_MODE != 0) && !is_printable(pt)) begin
               result_ok_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               dm_addr_d   = k_q[7:0];
               dm_wrdata_d = pt;
               dm_wren_d   = 1'b1;
               k_d         = k_inc;
               em_addr_d   = k_inc[7:0];
               state_d     = ST_PRGA_NXT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset forces IDLE and silences the dm port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         key_q       <= '0;
         i_q         <= '0;
         j_q         <= '0;
         si_q        <= '0;
         sj_q        <= '0;
         len_q       <= '0;
         k_q         <= '0;
         kidx_q      <= '0;
         em_addr_q   <= '0;
         dm_addr_q   <= '0;
         dm_wrdata_q <= '0;
         dm_wren_q   <= 1'b0;
         result_ok_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         i_q         <= i_d;
         j_q         <= j_d;
         si_q        <= si_d;
         sj_q        <= sj_d;
         len_q       <= len_d;
         k_q         <= k_d;
         kidx_q      <= kidx_d;
         em_addr_q   <= em_addr_d;
         dm_addr_q   <= dm_addr_d;
         dm_wrdata_q <= dm_wrdata_d;
         dm_wren_q   <= dm_wren_d;
         result_ok_q <= result_ok_d;
      end
   end

   assign ready     = (state_q == ST_IDLE);
   assign em_addr   = em_addr_q;
   assign dm_addr   = dm_addr_q;
   assign dm_wrdata = dm_wrdata_q;
   assign dm_wren   = dm_wren_q;
   assign result_ok = result_ok_q;

endmodule

// File: tb/tb_arc4_core_param.sv
// Bench: three engine instances (3-byte plain, 3-byte checked, 4-byte plain)
// against an RC4 reference model plus literal known-answer vectors.
module tb_arc4_core_param;

   localparam logic [127:0] CT_KEY  = 128'h09BBF316E8D940AF0AD3;
   localparam logic [127:0] PT_KEY  = 128'h09506C61696E74657874;
   localparam logic [127:0] CT_WIKI = 128'h051021BF0420;
   localparam logic [127:0] PT_WIKI = 128'h057065646961;
   localparam int           TMO     = 6000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        vld [3];
   logic [31:0] key_in [3];
   logic        rdy [3], rok [3], dmw [3];
   logic [7:0]  ema [3], emd [3], dma [3], dmd [3];

   logic [7:0]  em [3][256];
   logic [7:0]  dm [3][256];
   logic [7:0]  exp_data [3][256];
   int          exp_n [3];
   logic        exp_ok [3];
   int          got_n [3];
   int          tests = 0, fails = 0;

   arc4_core_param #(.KEY_BYTES(3), .CHECK_MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .valid(vld[0]), .ready(rdy[0]), .key(key_in[0][23:0]),
      .em_addr(ema[0]), .em_rddata(emd[0]), .dm_addr(dma[0]), .dm_wrdata(dmd[0]),
      .dm_wren(dmw[0]), .result_ok(rok[0]));
   arc4_core_param #(.KEY_BYTES(3), .CHECK_MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .valid(vld[1]), .ready(rdy[1]), .key(key_in[1][23:0]),
      .em_addr(ema[1]), .em_rddata(emd[1]), .dm_addr(dma[1]), .dm_wrdata(dmd[1]),
      .dm_wren(dmw[1]), .result_ok(rok[1]));
   arc4_core_param #(.KEY_BYTES(4), .CHECK_MODE(0)) u2 (
      .clk(clk), .rst_n(rst_n), .valid(vld[2]), .ready(rdy[2]), .key(key_in[2]),
      .em_addr(ema[2]), .em_rddata(emd[2]), .dm_addr(dma[2]), .dm_wrdata(dmd[2]),
      .dm_wren(dmw[2]), .result_ok(rok[2]));

   // External RAMs: 1-cycle synchronous ciphertext read, plaintext write.
   always @(posedge clk) begin
      for (int n = 0; n < 3; n++) begin
         emd[n] <= em[n][ema[n]];
         if (dmw[n] === 1'b1) dm[n][dma[n]] <= dmd[n];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [127:0] v, input int nb, input int b);
      return v[8*(nb-1-b) +: 8];
   endfunction

   // Every dm write must be the next expected (address, data) pair.
   always @(negedge clk) begin
      for (int n = 0; n < 3; n++) begin
         if (dmw[n] === 1'b1) begin
            if (got_n[n] >= exp_n[n]) begin
               tests++;
               fails++;
               $display("FAIL u%0d_extra_write: addr %0d data 0x%02h, only %0d writes expected",
                        n, dma[n], dmd[n], exp_n[n]);
            end else begin
               chk($sformatf("u%0d_wr_addr_%0d", n, got_n[n]), 32'(dma[n]), 32'(got_n[n] % 256));
               chk($sformatf("u%0d_wr_data_%0d", n, got_n[n]), 32'(dmd[n]), 32'(exp_data[n][got_n[n]]));
            end
            got_n[n]++;
         end
      end
   end

   // Plain RC4 reference producing the expected write stream and verdict.
   task automatic model(input int n, input logic [31:0] k, input int kb, input bit cm);
      int s [256];
      int i, j, t, len, p, cnt;
      logic ok;
      for (int x = 0; x < 256; x++) s[x] = x;
      j = 0;
      for (int x = 0; x < 256; x++) begin
         j = (j + s[x] + int'((k >> (8*(kb-1-(x % kb)))) & 32'hFF)) % 256;
         t = s[x]; s[x] = s[j]; s[j] = t;
      end
      len = int'(em[n][0]);
      exp_data[n][0] = em[n][0];
      cnt = 1; ok = 1'b1; i = 0; j = 0;
      for (int x = 1; x <= len; x++) begin
         i = (i + 1) % 256;
         j = (j + s[i]) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         p = int'(em[n][x]) ^ s[(s[i] + s[j]) % 256];
         if (cm && (p < 32 || p > 126)) begin
            ok = 1'b0;
            break;
         end
         exp_data[n][cnt] = p[7:0];
         cnt++;
      end
      exp_n[n]  = cnt;
      exp_ok[n] = ok;
      got_n[n]  = 0;
   endtask

   task automatic load_em(input int n, input logic [127:0] v, input int nb);
      for (int b = 0; b < nb; b++) em[n][b] = byte_of(v, nb, b);
   endtask

   task automatic chk_dm(input int n, input logic [127:0] v, input int nb, input string nm);
      for (int b = 0; b < nb; b++)
         chk($sformatf("%s_dm%0d", nm, b), 32'(dm[n][b]), 32'(byte_of(v, nb, b)));
   endtask

   task automatic chk_model(input int n, input logic [127:0] v, input int nb, input string nm);
      chk({nm, "_model_len"}, 32'(exp_n[n]), 32'(nb));
      for (int b = 0; b < nb; b++)
         chk($sformatf("%s_model%0d", nm, b), 32'(exp_data[n][b]), 32'(byte_of(v, nb, b)));
   endtask

   // Single-cycle valid pulse; key bus is scrambled right after acceptance.
   task automatic start(input int n, input logic [31:0] k, input string nm);
      @(posedge clk); #1;
      key_in[n] = k;
      vld[n]    = 1'b1;
      @(posedge clk); #1;
      vld[n]    = 1'b0;
      key_in[n] = 32'hDEADBEEF;
      @(negedge clk);
      chk({nm, "_busy"}, 32'(rdy[n]), 32'd0);
      chk({nm, "_ok_cleared"}, 32'(rok[n]), 32'd0);
   endtask

   task automatic wait_done(input int n, input string nm);
      int c = 0;
      while (rdy[n] !== 1'b1 && c < TMO) begin
         @(negedge clk);
         c++;
      end
      if (c >= TMO) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: ready still %b after %0d cycles, expected 1", nm, rdy[n], c);
      end else begin
         chk({nm, "_result_ok"}, 32'(rok[n]), 32'(exp_ok[n]));
         chk({nm, "_write_count"}, 32'(got_n[n]), 32'(exp_n[n]));
      end
   endtask

   initial begin
      for (int n = 0; n < 3; n++) begin
         vld[n] = 1'b0; key_in[n] = '0; got_n[n] = 0; exp_n[n] = 0; exp_ok[n] = 1'b0;
         for (int a = 0; a < 256; a++) begin em[n][a] = '0; dm[n][a] = '0; end
      end
      repeat (2) @(negedge clk);
      for (int n = 0; n < 3; n++) begin
         chk($sformatf("u%0d_rst_ready", n), 32'(rdy[n]), 32'd1);
         chk($sformatf("u%0d_rst_ok", n), 32'(rok[n]), 32'd0);
         chk($sformatf("u%0d_rst_wren", n), 32'(dmw[n]), 32'd0);
         chk($sformatf("u%0d_rst_em_addr", n), 32'(ema[n]), 32'd0);
         chk($sformatf("u%0d_rst_dm_addr", n), 32'(dma[n]), 32'd0);
         chk($sformatf("u%0d_rst_dm_data", n), 32'(dmd[n]), 32'd0);
      end
      @(posedge clk); #1 rst_n = 1'b1;

      // "Key"/"Plaintext" on the plain and the checked instance.
      load_em(0, CT_KEY, 10);
      model(0, 32'h4B6579, 3, 0);
      chk_model(0, PT_KEY, 10, "s1");
      start(0, 32'h4B6579, "s1_u0");
      wait_done(0, "s1_u0");
      chk_dm(0, PT_KEY, 10, "s1_u0");

      load_em(1, CT_KEY, 10);
      model(1, 32'h4B6579, 3, 1);
      start(1, 32'h4B6579, "s1_u1");
      wait_done(1, "s1_u1");
      chk_dm(1, PT_KEY, 10, "s1_u1");

      // "Wiki"/"pedia" on the 4-byte-key instance.
      load_em(2, CT_WIKI, 6);
      model(2, 32'h57696B69, 4, 0);
      chk_model(2, PT_WIKI, 6, "wiki");
      start(2, 32'h57696B69, "wiki");
      wait_done(2, "wiki");
      chk_dm(2, PT_WIKI, 6, "wiki");

      // Zero key with checking: aborts, dm past the last good byte untouched.
      model(1, 32'h0, 3, 1);
      chk("abort_model_ok", 32'(exp_ok[1]), 32'd0);
      start(1, 32'h0, "abort");
      wait_done(1, "abort");
      for (int b = 0; b < 10; b++)
         chk($sformatf("abort_dm%0d", b), 32'(dm[1][b]),
             32'((b < exp_n[1]) ? exp_data[1][b] : byte_of(PT_KEY, 10, b)));

      // Empty message: header write only.
      em[0][0] = 8'd0;
      model(0, 32'h4B6579, 3, 0);
      start(0, 32'h4B6579, "len0");
      wait_done(0, "len0");
      chk("len0_dm0", 32'(dm[0][0]), 32'd0);

      // Longest message with random data and key.
      for (int a = 1; a < 256; a++) em[0][a] = 8'($urandom_range(0, 255));
      em[0][0] = 8'd255;
      begin
         logic [31:0] rk;
         rk = 32'($urandom_range(0, 32'hFFFFFF));
         model(0, rk, 3, 0);
         chk("len255_model_n", 32'(exp_n[0]), 32'd256);
         start(0, rk, "len255");
         wait_done(0, "len255");
      end

      // Reset pulse in the middle of PRGA, then a clean rerun.
      load_em(0, CT_KEY, 10);
      model(0, 32'h4B6579, 3, 0);
      start(0, 32'h4B6579, "rstmid");
      begin
         int c = 0;
         while (got_n[0] < 3 && c < TMO) begin
            @(negedge clk);
            c++;
         end
         if (c >= TMO) begin
            tests++; fails++;
            $display("FAIL rstmid_reach_prga: only %0d writes after %0d cycles, expected 3", got_n[0], c);
         end
      end
      rst_n = 1'b0;
      #1;
      chk("rstmid_wren", 32'(dmw[0]), 32'd0);
      chk("rstmid_ready", 32'(rdy[0]), 32'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      model(0, 32'h4B6579, 3, 0);
      start(0, 32'h4B6579, "rerun");
      wait_done(0, "rerun");
      chk_dm(0, PT_KEY, 10, "rerun");

      // valid held high across two runs; key changes after first acceptance.
      model(0, 32'h4B6579, 3, 0);
      @(posedge clk); #1;
      key_in[0] = 32'h4B6579;
      vld[0]    = 1'b1;
      begin
         int c = 0;
         @(negedge clk);
         while (rdy[0] !== 1'b0 && c < 10) begin
            @(negedge clk);
            c++;
         end
         chk("hold_a_accepted", 32'(rdy[0]), 32'd0);
      end
      key_in[0] = 32'h123456;
      chk("hold_a_ok_cleared", 32'(rok[0]), 32'd0);
      wait_done(0, "hold_a");
      chk_dm(0, PT_KEY, 10, "hold_a");
      model(0, 32'h123456, 3, 0);
      @(negedge clk);
      chk("hold_b_accepted", 32'(rdy[0]), 32'd0);
      chk("hold_b_ok_cleared", 32'(rok[0]), 32'd0);
      repeat (100) @(negedge clk);
      vld[0] = 1'b0;
      wait_done(0, "hold_b");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

endmodule
